fb_swap_ctrl: RTL
=================

Name: fb_swap_ctrl

Overview:
Scan-side controller for the double-buffered LCD framebuffer. Runs in the pixel (read) clock domain and generates the raster read address. It accepts a "frame complete" toggle from the write-side renderer and issues the buffer-swap pulse only at vertical-blank start, so the panel never shows a torn frame. It returns a swap acknowledge toggle to the writer and keeps swap and frame-repeat statistics.

Parameters:
ADDR_W, 32, width of rad output (matches framebuffer address width)
FRAME_PIXELS, 76800, pixels per frame; rad wraps after FRAME_PIXELS-1
SWITCH_W, 2, cycles switch is held high per swap (min 1)
CNT_W, 16, width of swap_count / repeat_count

Ports:
clk  in  1  pixel clock, same clock as framebuffer rclk
rst_n  in  1  reset, asynchronous, active-low
de  in  1  active-pixel data enable from LCD timing generator
vblank_start  in  1  single-cycle pulse at first line of vertical blank
wr_done_tgl  in  1  toggles once per completed frame; asynchronous (write clock domain)
rad  out  ADDR_W  framebuffer read address
switch  out  1  swap strobe to framebuffer switch input (rising edge swaps)
front  out  1  shadow of framebuffer buffer-select; toggles on each swap
wr_ack_tgl  out  1  toggles once per completed swap; writer may start next frame
busy  out  1  swap requested but not yet completed
overrun  out  1  sticky: new wr_done edge arrived while busy
swap_count  out  CNT_W  completed swaps, wraps
repeat_count  out  CNT_W  vblanks with no pending frame (frame repeated), wraps

Behaviour:
- Reset (async, rst_n low): rad=0, switch=0, front=0, wr_ack_tgl=0, busy=0, overrun=0, both counters 0, sync flops=0, FSM=IDLE. front=0 matches framebuffer reset select.
- Input sync: wr_done_tgl -> 2-flop synchronizer -> 3rd flop; req = XOR of flops 2 and 3. One-cycle req pulse, 3 clk after toggle settles.
- Read address: each cycle with de=1, rad <= rad+1; at rad=FRAME_PIXELS-1 with de=1, rad <= 0. vblank_start forces rad <= 0 (priority over de). Holds when de=0.
- FSM states:
  - IDLE: req -> PENDING, busy=1. If req and vblank_start in the same cycle -> PULSE directly. vblank_start without req -> repeat_count+1.
  - PENDING: wait for vblank_start -> PULSE. No repeat_count increment.
  - PULSE: switch=1 for SWITCH_W cycles, then -> HOLD.
  - HOLD: switch=0 for 1 cycle. On exit: front toggles, wr_ack_tgl toggles, swap_count+1, busy=0, -> IDLE.
- switch is registered; no glitches. Minimum low time between pulses is >= 1 frame by construction.
- Latency: vblank_start in PENDING -> switch high next cycle. wr_ack_tgl toggles SWITCH_W+1 cycles after switch rises.
- req while busy (PENDING/PULSE/HOLD): overrun <= 1 (sticky until reset). The request is dropped; no queued second swap.
- vblank_start during PULSE/HOLD: ignored by the FSM (no repeat count); still resets rad.
- Counters wrap at 2^CNT_W-1 -> 0 silently.
- rst_n asserted mid-PULSE: switch drops to 0 immediately; front returns to 0, consistent with the framebuffer's own reset.

Test Plan:
- Reset: hold rst_n low 5 clk with de=1 -> rad=0, switch=0, front=0, all counters 0; release -> rad counts 0,1,2 on consecutive de cycles.
- Address wrap: FRAME_PIXELS=16, de held high 20 cycles -> rad sequence 0..15,0,1,2,3; pulse vblank_start at rad=7 -> next rad=0.
- Normal swap: SWITCH_W=2; toggle wr_done_tgl; 10 clk later pulse vblank_start -> busy=1 within 3 clk; switch high exactly 2 cycles starting the cycle after vblank_start; then front=1, wr_ack_tgl=1, swap_count=1, busy=0.
- Repeat frames: 3 vblank_start pulses with no wr_done toggle -> repeat_count=3, switch never asserted, front=0.
- Simultaneous: align sync req with vblank_start in IDLE -> switch rises next cycle, repeat_count unchanged, swap_count=1.
- Overrun/reset: toggle wr_done twice before vblank -> overrun=1, only one swap (swap_count=1). Then assert rst_n mid-PULSE -> switch=0 and front=0 immediately, overrun=0.

Source files
------------

// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl: pixel-clock side controller for the double-buffered LCD
// framebuffer. Generates the raster read address, synchronises the writer's
// frame-complete toggle, and issues the buffer-swap strobe only at
// vertical-blank start so a frame is never torn on the panel.
module fb_swap_ctrl #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned FRAME_PIXELS = 76800,
    parameter int unsigned SWITCH_W     = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              de,
    input  logic              vblank_start,
    input  logic              wr_done_tgl,
    output logic [ADDR_W-1:0] rad,
    output logic              switch,
    output logic              front,
    output logic              wr_ack_tgl,
    output logic              busy,
    output logic              overrun,
    output logic [CNT_W-1:0]  swap_count,
    output logic [CNT_W-1:0]  repeat_count
);

    localparam int unsigned       PCNT_W     = (SWITCH_W > 1) ? $clog2(SWITCH_W) : 1;
    localparam logic [ADDR_W-1:0] RAD_LAST   = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST  = PCNT_W'(SWITCH_W - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_PULSE   = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic               w_req;

    logic [ADDR_W-1:0]  r_rad;
    logic [PCNT_W-1:0]  r_pcnt;
    logic               r_switch;
    logic               r_front;
    logic               r_wr_ack_tgl;
    logic               r_busy;
    logic               r_overrun;
    logic [CNT_W-1:0]   r_swap_count;
    logic [CNT_W-1:0]   r_repeat_count;

    logic [PCNT_W-1:0]  w_pcnt_nxt;
    logic               w_switch_nxt;
    logic               w_front_nxt;
    logic               w_wr_ack_nxt;
    logic               w_busy_nxt;
    logic               w_overrun_nxt;
    logic [CNT_W-1:0]   w_swap_count_nxt;
    logic [CNT_W-1:0]   w_repeat_count_nxt;

    // Bring the writer's toggle into the pixel domain; edge of sync2/sync3 is a one-cycle request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= wr_done_tgl;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_req = r_sync2 ^ r_sync3;

    // Raster read address: advance on active pixels, wrap at frame end, restart at vblank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rad <= '0;
        end else if (vblank_start) begin
            r_rad <= '0;
        end else if (de) begin
            if (r_rad == RAD_LAST) begin
                r_rad <= '0;
            end else begin
                r_rad <= r_rad + 1'b1;
            end
        end
    end

    // Swap FSM state register together with the registered outputs it drives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_pcnt         <= '0;
            r_switch       <= 1'b0;
            r_front        <= 1'b0;
            r_wr_ack_tgl   <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
            r_swap_count   <= '0;
            r_repeat_count <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_pcnt         <= w_pcnt_nxt;
            r_switch       <= w_switch_nxt;
            r_front        <= w_front_nxt;
            r_wr_ack_tgl   <= w_wr_ack_nxt;
            r_busy         <= w_busy_nxt;
            r_overrun      <= w_overrun_nxt;
            r_swap_count   <= w_swap_count_nxt;
            r_repeat_count <= w_repeat_count_nxt;
        end
    end

    // Next state: a request waits for vblank, then the strobe runs and a one-cycle hold follows
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = vblank_start ? S_PULSE : S_PENDING;
                end
            end
            S_PENDING: begin
                if (vblank_start) begin
                    w_state_nxt = S_PULSE;
                end
            end
            S_PULSE: begin
                if (r_pcnt == PCNT_LAST) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; a request arriving while busy is dropped and flagged
    always_comb begin
        w_pcnt_nxt         = '0;
        w_switch_nxt       = 1'b0;
        w_front_nxt        = r_front;
        w_wr_ack_nxt       = r_wr_ack_tgl;
        w_busy_nxt         = r_busy;
        w_overrun_nxt      = r_overrun | (w_req && (r_state != S_IDLE));
        w_swap_count_nxt   = r_swap_count;
        w_repeat_count_nxt = r_repeat_count;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_busy_nxt   = 1'b1;
                    w_switch_nxt = vblank_start;
                end else if (vblank_start) begin
                    w_repeat_count_nxt = r_repeat_count + 1'b1;
                end
            end
            S_PENDING: begin
                w_switch_nxt = vblank_start;
            end
            S_PULSE: begin
                if (r_pcnt != PCNT_LAST) begin
                    w_switch_nxt = 1'b1;
                    w_pcnt_nxt   = r_pcnt + 1'b1;
                end
            end
            S_HOLD: begin
                w_front_nxt      = ~r_front;
                w_wr_ack_nxt     = ~r_wr_ack_tgl;
                w_swap_count_nxt = r_swap_count + 1'b1;
                w_busy_nxt       = 1'b0;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    assign rad          = r_rad;
    assign switch       = r_switch;
    assign front        = r_front;
    assign wr_ack_tgl   = r_wr_ack_tgl;
    assign busy         = r_busy;
    assign overrun      = r_overrun;
    assign swap_count   = r_swap_count;
    assign repeat_count = r_repeat_count;

endmodule
